// File: rtl/hilo_unit.sv
// hilo_unit: EX-stage HI/LO controller that drives a slow negedge multiplier and owns the HI/LO pair.
// Define MADD_EN to enable op 7 (MADD), which accumulates the signed product into {hi,lo}.
module hilo_unit #(
    parameter int ACC_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [2:0]           op,
    input  logic [31:0]          rs_val,
    input  logic [31:0]          rt_val,
    input  logic                 flush,
    input  logic                 pipe_enable,
    output logic                 mul_start,
    output logic                 mul_signed,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic                 mul_annul,
    output logic                 mul_enable,
    input  logic [ACC_WIDTH-1:0] mul_result,
    input  logic                 mul_ready,
    output logic                 stall,
    output logic [31:0]          rd_data,
    output logic [31:0]          hi,
    output logic [31:0]          lo
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    state_t               state;
    state_t               state_next;
    logic                 is_mul;
    logic                 live;
    logic                 busy_start;
    logic                 annul;
    logic                 commit;
    logic                 wr_hi;
    logic                 wr_lo;
    logic [ACC_WIDTH-1:0] acc_next;

    assign live = op_valid & ~flush;

`ifdef MADD_EN
    logic madd_q;

    assign is_mul   = live & ((op == OP_MULT) | (op == OP_MULTU) | (op == OP_MADD));
    assign acc_next = madd_q ? ({hi, lo} + mul_result) : mul_result;
`else
    assign is_mul   = live & ((op == OP_MULT) | (op == OP_MULTU));
    assign acc_next = mul_result;
`endif

    assign wr_hi = (state == IDLE) & live & pipe_enable & (op == OP_MTHI);
    assign wr_lo = (state == IDLE) & live & pipe_enable & (op == OP_MTLO);

    // Flush beats a same-cycle Ready so an annulled multiply never commits.
    always_comb begin
        state_next = state;
        busy_start = 1'b0;
        annul      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy_start = 1'b1;
                if (flush) begin
                    annul      = 1'b1;
                    state_next = IDLE;
                end else if (mul_ready) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (pipe_enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hi         <= 32'd0;
            lo         <= 32'd0;
            mul_a      <= 32'd0;
            mul_b      <= 32'd0;
            mul_signed <= 1'b0;
`ifdef MADD_EN
            madd_q     <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if ((state == IDLE) && is_mul) begin
                mul_a      <= rs_val;
                mul_b      <= rt_val;
                mul_signed <= (op != OP_MULTU);
`ifdef MADD_EN
                madd_q     <= (op == OP_MADD);
`endif
            end
            if (commit) begin
                {hi, lo} <= acc_next;
            end else begin
                if (wr_hi) begin
                    hi <= rs_val;
                end
                if (wr_lo) begin
                    lo <= rs_val;
                end
            end
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign mul_start  = busy_start & ~rst;
    assign mul_annul  = annul & ~rst;
    assign mul_enable = pipe_enable;
    assign stall      = ~rst & (((state == IDLE) & is_mul) | (state == BUSY));
    assign rd_data    = rst              ? 32'd0 :
                        (op == OP_MFHI)  ? hi    :
                        (op == OP_MFLO)  ? lo    : 32'd0;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed plus randomized bench for hilo_unit with a negedge multiplier stub.
// Expected HI/LO come from an architectural model of the HI/LO pair; MADD_EN selects the MADD checks.
module tb_hilo_unit;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

`ifdef MADD_EN
    localparam bit MaddOn = 1'b1;
`else
    localparam bit MaddOn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        pipe_enable;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_annul;
    logic        mul_enable;
    logic [63:0] mul_result;
    logic        mul_ready;
    logic        stall;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total;
    int          bad;
    logic [63:0] refAcc;

    hilo_unit #(.ACC_WIDTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .flush       (flush),
        .pipe_enable (pipe_enable),
        .mul_start   (mul_start),
        .mul_signed  (mul_signed),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_annul   (mul_annul),
        .mul_enable  (mul_enable),
        .mul_result  (mul_result),
        .mul_ready   (mul_ready),
        .stall       (stall),
        .rd_data     (rd_data),
        .hi          (hi),
        .lo          (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier stub with one iteration: Ready rises on the third negedge after Start.
    logic [1:0]  mcnt;
    logic [63:0] stubA;
    logic [63:0] stubB;
    assign stubA = {{32{mul_signed & mul_a[31]}}, mul_a};
    assign stubB = {{32{mul_signed & mul_b[31]}}, mul_b};

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            mul_ready  <= 1'b0;
            mul_result <= 64'd0;
            mcnt       <= 2'd0;
        end else if (!mul_start || mul_annul) begin
            mul_ready <= 1'b0;
            mcnt      <= 2'd0;
        end else if (!mul_ready) begin
            if (mcnt == 2'd2) begin
                mul_ready  <= 1'b1;
                mul_result <= stubA * stubB;
            end else begin
                mcnt <= mcnt + 2'd1;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: observed=%h required=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randVal();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // One non-multiply instruction in EX for a single cycle.
    task automatic applyStimulus(input logic [2:0] sop, input logic [31:0] a, input logic v,
                                 input logic fl, input logic pe);
        logic [31:0] expRd;
        op_valid    = v;
        op          = sop;
        rs_val      = a;
        rt_val      = $urandom;
        flush       = fl;
        pipe_enable = pe;
        #1;
        checkOutput("simple_stall", 64'(stall), 64'(1'b0));
        checkOutput("mul_enable", 64'(mul_enable), 64'(pe));
        case (sop)
            OP_MFHI: expRd = refAcc[63:32];
            OP_MFLO: expRd = refAcc[31:0];
            default: expRd = 32'd0;
        endcase
        checkOutput("rd_data", 64'(rd_data), 64'(expRd));
        if (v && !fl && pe) begin
            if (sop == OP_MTHI) refAcc[63:32] = a;
            if (sop == OP_MTLO) refAcc[31:0]  = a;
        end
        tick();
        op_valid    = 1'b0;
        op          = OP_NOP;
        flush       = 1'b0;
        pipe_enable = 1'b1;
        #1;
        checkOutput("hilo_simple", {hi, lo}, refAcc);
    endtask

    // Multiply-class instruction held in EX until the unit releases it.
    task automatic doMul(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                         input int flushAt, input int holdDone);
        logic [63:0] expAcc;
        logic [63:0] sprod;
        int          busyCycles;
        bit          flushed;
        sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        case (mop)
            OP_MULTU: expAcc = {32'd0, a} * {32'd0, b};
            OP_MULT:  expAcc = sprod;
            default:  expAcc = refAcc + sprod;
        endcase
        op_valid    = 1'b1;
        op          = mop;
        rs_val      = a;
        rt_val      = b;
        flush       = 1'b0;
        pipe_enable = 1'b1;
        #1;
        checkOutput("issue_stall", 64'(stall), 64'(1'b1));
        tick();
        busyCycles = 0;
        flushed    = 1'b0;
        while (busyCycles < 8 && !flushed) begin
            if (busyCycles + 1 == flushAt) flush = 1'b1;
            #1;
            if (!stall) break;
            busyCycles++;
            checkOutput("busy_start", 64'(mul_start), 64'(1'b1));
            checkOutput("busy_annul", 64'(mul_annul), 64'(flush));
            if (busyCycles == 1) begin
                checkOutput("mul_a", 64'(mul_a), 64'(a));
                checkOutput("mul_b", 64'(mul_b), 64'(b));
                checkOutput("mul_signed", 64'(mul_signed), 64'(mop != OP_MULTU));
            end
            if (flush) flushed = 1'b1;
            tick();
        end
        if (flushed) begin
            flush    = 1'b0;
            op_valid = 1'b0;
            op       = OP_NOP;
            #1;
            checkOutput("flush_stall", 64'(stall), 64'(1'b0));
            checkOutput("flush_start", 64'(mul_start), 64'(1'b0));
            checkOutput("flush_hilo", {hi, lo}, refAcc);
        end else begin
            checkOutput("stall_cycles", 64'(busyCycles), 64'(3));
            checkOutput("done_start", 64'(mul_start), 64'(1'b0));
            checkOutput("commit_hilo", {hi, lo}, expAcc);
            refAcc = expAcc;
            for (int h = 0; h < holdDone; h++) begin
                pipe_enable = 1'b0;
                tick();
                #1;
                checkOutput("hold_stall", 64'(stall), 64'(1'b0));
                checkOutput("hold_hilo", {hi, lo}, refAcc);
            end
            pipe_enable = 1'b1;
            tick();
            op_valid = 1'b0;
            op       = OP_NOP;
            #1;
            checkOutput("release_stall", 64'(stall), 64'(1'b0));
        end
    endtask

    initial begin
        logic [2:0] rop;
        bit         rIsMul;
        total       = 0;
        bad         = 0;
        refAcc      = 64'd0;
        rst         = 1'b1;
        op_valid    = 1'b0;
        op          = OP_NOP;
        rs_val      = 32'd0;
        rt_val      = 32'd0;
        flush       = 1'b0;
        pipe_enable = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_hilo", {hi, lo}, 64'd0);
        checkOutput("rst_stall", 64'(stall), 64'(1'b0));
        checkOutput("rst_start", 64'(mul_start), 64'(1'b0));
        checkOutput("rst_annul", 64'(mul_annul), 64'(1'b0));
        checkOutput("rst_rd", 64'(rd_data), 64'd0);
        checkOutput("rst_ab", {mul_a, mul_b}, 64'd0);
        checkOutput("rst_signed", 64'(mul_signed), 64'(1'b0));
        rst = 1'b0;
        tick();

        doMul(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0);
        checkOutput("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        doMul(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0);
        checkOutput("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        applyStimulus(OP_MFHI, 32'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(OP_MFLO, 32'd0, 1'b1, 1'b0, 1'b1);

        for (int k = 1; k <= 3; k++) begin
            doMul(OP_MULT, 32'd7, 32'd9, k, 0);
        end
        checkOutput("flush_keep", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        applyStimulus(OP_MTHI, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        applyStimulus(OP_MTHI, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        applyStimulus(OP_MTLO, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b1);
        applyStimulus(OP_MFHI, 32'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(OP_MFLO, 32'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("mt_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        doMul(OP_MULTU, 32'h8000_0000, 32'h8000_0000, 0, 2);
        checkOutput("hold_product", {hi, lo}, 64'h4000_0000_0000_0000);

        // Reset pulsed two cycles into a multiply, while the MULT is still presented.
        op_valid = 1'b1;
        op       = OP_MULT;
        rs_val   = 32'd11;
        rt_val   = 32'd13;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst_hilo", {hi, lo}, 64'd0);
        checkOutput("midrst_stall", 64'(stall), 64'(1'b0));
        checkOutput("midrst_start", 64'(mul_start), 64'(1'b0));
        op_valid = 1'b0;
        op       = OP_NOP;
        #1;
        rst    = 1'b0;
        refAcc = 64'd0;
        tick();
        doMul(OP_MULT, 32'd2, 32'd3, 0, 0);
        checkOutput("postrst_mult", {hi, lo}, 64'd6);

        applyStimulus(OP_MTHI, 32'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(OP_MTLO, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
`ifdef MADD_EN
        doMul(OP_MADD, 32'd1, 32'd1, 0, 0);
        checkOutput("madd_carry", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        applyStimulus(OP_MADD, 32'd1, 1'b1, 1'b0, 1'b1);
        checkOutput("op7_nop", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int n = 0; n < 60; n++) begin
            rop    = 3'($urandom_range(0, 7));
            rIsMul = (rop == OP_MULT) || (rop == OP_MULTU) || ((rop == OP_MADD) && MaddOn);
            if (rIsMul) begin
                doMul(rop, randVal(), randVal(),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      int'($urandom_range(0, 2)));
            end else begin
                applyStimulus(rop, randVal(), 1'($urandom_range(0, 4) != 0),
                              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- EX-stage HI/LO controller; sits directly upstream and downstream of the slow multiplier.
- Decodes MULT/MULTU/MTHI/MTLO/MFHI/MFLO and drives the multiplier's Start/Signed/A/B/Annul/Enable.
- Stalls the pipeline while a product is pending, then commits the 64-bit result into the architectural HI/LO registers.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- ACC_WIDTH, 64, width of the {HI,LO} register pair; fixed at 64, present for lint only.

Ports:
- clk  in  1  clock, posedge logic; the multiplier runs on negedge of the same clock
- rst  in  1  asynchronous active-high reset
- op_valid  in  1  EX-stage instruction valid
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 MADD (only with MADD_EN)
- rs_val  in  32  rs operand
- rt_val  in  32  rt operand
- flush  in  1  annul the current EX instruction (branch/exception)
- pipe_enable  in  1  pipeline advancing this cycle (no external freeze)
- mul_start  out  1  multiplier Start; held high while the request is live
- mul_signed  out  1  multiplier Signed
- mul_a  out  32  multiplier A, registered
- mul_b  out  32  multiplier B, registered
- mul_annul  out  1  multiplier Annul
- mul_enable  out  1  multiplier Enable; equals pipe_enable
- mul_result  in  64  multiplier Result
- mul_ready  in  1  multiplier Ready
- stall  out  1  freeze IF/ID/EX
- rd_data  out  32  MFHI/MFLO result
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; hi=lo=0; mul_a=mul_b=0; mul_signed=0.
  - All outputs 0: mul_start, stall, rd_data, mul_annul.
  - An in-flight multiply is dropped.
- States: IDLE, BUSY, DONE.
- is_mul = op_valid & ~flush & (op==MULT | op==MULTU | op==MADD).
- IDLE:
  - On is_mul: latch mul_a=rs_val, mul_b=rt_val, mul_signed=(op!=MULTU), and the op. Go to BUSY.
  - op_valid & ~flush & pipe_enable & MTHI: hi<=rs_val at the edge.
  - op_valid & ~flush & pipe_enable & MTLO: lo<=rs_val at the edge.
- BUSY:
  - mul_start=1.
  - mul_ready=1 at a posedge: {hi,lo}<=mul_result (MULT/MULTU); go to DONE.
  - mul_ready is ignored on the edge where BUSY is entered. The multiplier clears a stale Ready on the following negedge.
- DONE:
  - mul_start=0; stall=0 so the multiply instruction leaves EX.
  - pipe_enable=1: go to IDLE.
  - pipe_enable=0: stay in DONE; the held instruction is never reissued.
- stall = (state==IDLE & is_mul) | state==BUSY. Combinational.
- Latency: request accepted at edge T. With the current multiplier (MAX_ITERATION=1), mul_ready is sampled high at T+3. HI/LO are written at T+3; stall is low in cycle T+3..T+4.
- Flush in BUSY:
  - mul_annul=1 combinationally for that cycle; next state IDLE; hi/lo unchanged.
  - Flush with mul_ready in the same cycle: flush wins, no write.
- Flush in DONE: ignored; the result is already committed.
- rd_data = (op==MFHI)?hi : (op==MFLO)?lo : 0. Combinational from the current registers; no bypass needed.
  - An MF directly after MT/MULT reads the committed value, because the writer commits before the reader enters EX.
- Unused op codes, and op 7 without MADD_EN: treated as NOP.

Optional Feature:
- MADD_EN defined:
  - op 7 (MADD) issues a signed multiply.
  - At commit, {hi,lo}<={hi,lo}+mul_result (64-bit wrap, no overflow flag).
  - The 64-bit adder is registered in the BUSY->DONE edge.
- MADD_EN undefined: no adder is present; op 7 is a NOP.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFD, rt=5 -> stall high 3 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall low at T+3.
- MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE; the following MFHI gives rd_data=1 and MFLO gives rd_data=0xFFFFFFFE.
- MULT 7*9, flush asserted at T+1 -> mul_annul pulse for 1 cycle, state IDLE, hi/lo keep prior values, stall low next cycle.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0, then MFHI and MFLO -> rd_data 0x12345678 then 0x9ABCDEF0; pipe_enable=0 on MTHI -> no write.
- rst pulsed mid-BUSY (at T+2) -> hi=lo=0, stall=0, mul_start=0 immediately. A subsequent MULT 2*3 gives lo=6, hi=0.
- MADD_EN: {hi,lo}=0x00000000_FFFFFFFF, MADD 1*1 -> hi=1, lo=0. Without the macro, op 7 leaves hi/lo unchanged and never stalls.
